// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the on-chip memory read scheduler: FSM state
// encoding, memory geometry and the default engine watchdog limit.
package onchip_mem_pkg;

  localparam int ONCHIP_MEM_ADDR_W  = 18;
  localparam int ONCHIP_MEM_BYTES   = 262144;
  localparam int ONCHIP_MEM_TIMEOUT = 65535;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/onchip_mem_read_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req  : request vector, one bit per requester
//   i_ptr  : highest-priority index this round
//   o_gnt  : one-hot grant, zero when nothing requests
//   o_id   : encoded index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [1:0]         o_id
);

  // Walk from the pointer and wrap; the first requester seen wins.
  always_comb begin : pick
    int   w_idx;
    logic w_found;
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = 2'(w_idx);
      end
    end
  end

endmodule

// File: rtl/onchip_mem_read_sched.sv
// Shares the single on-chip memory read engine between NUM_REQ requesters.
// One descriptor (byte address + byte length) is accepted at a time,
// range-checked, launched on the engine and tracked by a watchdog.
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid/addr/len_in       : per-requester descriptors (flattened slices)
//   req_ready_out               : combinational one-hot grant (IDLE only)
//   req_done_out/req_error_out  : one-cycle completion / rejection pulses
//   busy_out, grant_id_out      : scheduler status, current/last owner
//   eng_*                       : engine start address, length, start, done
module onchip_mem_read_sched
  import onchip_mem_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ONCHIP_MEM_ADDR_W,
  parameter int LEN_W   = 32,
  parameter int TIMEOUT = ONCHIP_MEM_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_in,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  output logic [NUM_REQ-1:0]         req_done_out,
  output logic [NUM_REQ-1:0]         req_error_out,
  output logic                       busy_out,
  output logic [1:0]                 grant_id_out,
  output logic [ADDR_W-1:0]          eng_start_addr_out,
  output logic [LEN_W-1:0]           eng_byte_len_out,
  output logic                       eng_read_start_out,
  input  logic                       eng_read_done_in
);

  localparam int SUM_W = ADDR_W + LEN_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [1:0]          r_id, r_ptr;
  logic [WD_W-1:0]     r_wd;
  logic [NUM_REQ-1:0]  r_done, r_err;

  logic [NUM_REQ-1:0]  w_gnt, w_ready;
  logic [1:0]          w_gnt_id;
  logic                w_accept, w_fin_ok, w_fin_err, w_start, w_busy;
  logic [SUM_W-1:0]    w_end;
  logic                w_range_bad;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req (req_valid_in),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_id  (w_gnt_id)
  );

  // End address computed wide enough that addr + len can never wrap.
  assign w_end       = SUM_W'(r_addr) + SUM_W'(r_len);
  assign w_range_bad = w_end > (SUM_W'(1) << ADDR_W);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fin_ok    = 1'b0;
    w_fin_err   = 1'b0;
    w_start     = 1'b0;
    w_busy      = 1'b1;
    w_ready     = '0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        // Keep ready low while reset is asserted so every output reads 0.
        w_ready = rst ? '0 : w_gnt;
        if (|w_gnt) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_len == '0) begin
          w_fin_ok    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_range_bad) begin
          w_fin_err   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_start     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Done is checked first so a same-cycle expiry loses to it.
        if (eng_read_done_in) begin
          w_fin_ok    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
          w_fin_err   = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Swallow the late done so the engine is never restarted mid-read.
        if (eng_read_done_in) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_wd    <= '0;
      r_done  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_fin_ok  ? (NUM_REQ'(1) << r_id) : '0;
      r_err   <= w_fin_err ? (NUM_REQ'(1) << r_id) : '0;
      if (w_accept) begin
        r_addr <= req_addr_in[int'(w_gnt_id)*ADDR_W +: ADDR_W];
        r_len  <= req_len_in[int'(w_gnt_id)*LEN_W +: LEN_W];
        r_id   <= w_gnt_id;
        r_ptr  <= (w_gnt_id == 2'(NUM_REQ - 1)) ? 2'd0 : w_gnt_id + 2'd1;
      end
      if (w_start)               r_wd <= '0;
      else if (r_state == ST_WAIT) r_wd <= r_wd + WD_W'(1);
    end
  end

  assign req_ready_out      = w_ready;
  assign req_done_out       = r_done;
  assign req_error_out      = r_err;
  assign busy_out           = w_busy;
  assign grant_id_out       = r_id;
  assign eng_start_addr_out = r_addr;
  assign eng_byte_len_out   = r_len;
  assign eng_read_start_out = w_start;

endmodule

// File: tb/tb_onchip_mem_read_sched.sv
module tb_onchip_mem_read_sched;

  localparam int NREQ = 3;
  localparam int AW   = 18;
  localparam int LW   = 32;
  localparam int TMO  = 50;
  localparam longint MEM_BYTES = 262144;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid_in = '0;
  logic [NREQ*AW-1:0] req_addr_in = '0;
  logic [NREQ*LW-1:0] req_len_in  = '0;
  logic [NREQ-1:0]   req_ready_out, req_done_out, req_error_out;
  logic              busy_out;
  logic [1:0]        grant_id_out;
  logic [AW-1:0]     eng_start_addr_out;
  logic [LW-1:0]     eng_byte_len_out;
  logic              eng_read_start_out;
  logic              eng_read_done_in = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: next round-robin priority and requester descriptors.
  int          mdl_ptr = 0;
  logic [AW-1:0] m_addr [NREQ];
  logic [LW-1:0] m_len  [NREQ];

  onchip_mem_read_sched #(
    .NUM_REQ(NREQ), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_in       (req_valid_in),
    .req_addr_in        (req_addr_in),
    .req_len_in         (req_len_in),
    .req_ready_out      (req_ready_out),
    .req_done_out       (req_done_out),
    .req_error_out      (req_error_out),
    .busy_out           (busy_out),
    .grant_id_out       (grant_id_out),
    .eng_start_addr_out (eng_start_addr_out),
    .eng_byte_len_out   (eng_byte_len_out),
    .eng_read_start_out (eng_read_start_out),
    .eng_read_done_in   (eng_read_done_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic drive_desc(input logic [NREQ-1:0] vmask);
    for (int i = 0; i < NREQ; i++) begin
      req_addr_in[i*AW +: AW] = m_addr[i];
      req_len_in[i*LW +: LW]  = m_len[i];
    end
    req_valid_in = vmask;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the
  // first IDLE cycle after the transaction so the next grant can follow.
  // lat: cycles from the start pulse to the engine done pulse.
  task automatic do_txn(input logic [NREQ-1:0] vmask, input int lat);
    int id;
    logic [NREQ-1:0] oh;
    longint endb;
    bit zero, bad;
    drive_desc(vmask);
    #1;
    id = pick(vmask, mdl_ptr);
    oh = NREQ'(1) << id;
    chk("ready", req_ready_out, oh);
    mdl_ptr = (id + 1) % NREQ;
    zero = (m_len[id] == 0);
    endb = longint'(m_addr[id]) + longint'(m_len[id]);
    bad  = !zero && (endb > MEM_BYTES);
    @(negedge clk);
    req_valid_in[id] = 1'b0;
    #1;
    chk("check_busy", busy_out, 1);
    chk("grant_id", grant_id_out, id);
    chk("check_nostart", eng_read_start_out, 0);
    @(negedge clk); #1;
    if (zero) begin
      chk("zero_done", req_done_out, oh);
      chk("zero_nostart", eng_read_start_out, 0);
      chk("zero_busy", busy_out, 0);
    end else if (bad) begin
      chk("range_err", req_error_out, oh);
      chk("range_nostart", eng_read_start_out, 0);
      chk("range_busy", busy_out, 0);
    end else begin
      chk("start", eng_read_start_out, 1);
      chk("start_addr", eng_start_addr_out, m_addr[id]);
      chk("start_len", eng_byte_len_out, m_len[id]);
      chk("start_nodone", req_done_out | req_error_out, 0);
      for (int k = 1; k <= lat + 1; k++) begin
        @(negedge clk);
        eng_read_done_in = (k == lat);
        #1;
        chk("wait_done", req_done_out,
            (lat <= TMO && k == lat + 1) ? oh : '0);
        chk("wait_err", req_error_out,
            (lat > TMO && k == TMO + 1) ? oh : '0);
        chk("wait_busy", busy_out, (k <= lat));
        if (k == lat) begin
          chk("hold_addr", eng_start_addr_out, m_addr[id]);
          chk("hold_len", eng_byte_len_out, m_len[id]);
          chk("no_restart", eng_read_start_out, 0);
        end
      end
      eng_read_done_in = 1'b0;
    end
  endtask

  task automatic rand_desc(input int i);
    int c;
    c = $urandom_range(0, 9);
    m_addr[i] = AW'($urandom_range(0, 262143));
    if (c == 0)      m_len[i] = '0;
    else if (c == 1) m_len[i] = 32'hFFFF_FFFF;
    else if (c <= 3) m_len[i] = LW'(MEM_BYTES - longint'(m_addr[i]) + $urandom_range(1, 500));
    else             m_len[i] = LW'($urandom_range(1, 262144 - int'(m_addr[i])));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin m_addr[i] = '0; m_len[i] = '0; end

    // Reset state
    @(negedge clk); @(negedge clk);
    req_valid_in = 3'b111;
    #1;
    chk("rst_ready", req_ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_pulses", {req_done_out, req_error_out}, 0);
    chk("rst_eng", {eng_start_addr_out, eng_byte_len_out, eng_read_start_out}, 0);
    chk("rst_gid", grant_id_out, 0);
    req_valid_in = '0;
    rst = 1'b0;

    // Single request, engine done 20 cycles after start
    m_addr[0] = 18'h00040; m_len[0] = 100;
    do_txn(3'b001, 20);

    // Rotation under full load, then a lone requester back to back
    for (int i = 0; i < NREQ; i++) begin m_addr[i] = AW'(i * 4096); m_len[i] = 64; end
    for (int n = 0; n < 6; n++) do_txn(3'b111, 3);
    do_txn(3'b001, 2);
    do_txn(3'b001, 2);

    // Zero length on req1
    m_len[1] = 0;
    do_txn(3'b010, 5);
    // Range boundary on req2
    m_addr[2] = 18'h3FFF0; m_len[2] = 32;
    do_txn(3'b100, 5);
    m_addr[2] = 18'h3FFE0; m_len[2] = 32;
    do_txn(3'b100, 4);
    // Length that would overflow a narrow adder
    m_addr[0] = 18'h00010; m_len[0] = 32'hFFFF_FFF8;
    do_txn(3'b001, 4);

    // Timeout then late done, and done at the expiry boundary
    m_addr[0] = 18'h00100; m_len[0] = 16;
    do_txn(3'b001, 70);
    do_txn(3'b001, TMO);
    do_txn(3'b001, TMO + 1);

    // Reset during WAIT
    m_addr[0] = 18'h00200; m_len[0] = 8; m_len[1] = 8;
    drive_desc(3'b001);
    @(negedge clk); req_valid_in = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1;
    chk("pre_rst_busy", busy_out, 1);
    rst = 1'b1;
    req_valid_in = 3'b011;
    @(negedge clk); #1;
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_ready", req_ready_out, 0);
    chk("mid_rst_pulses", {req_done_out, req_error_out, eng_read_start_out}, 0);
    chk("mid_rst_eng", {eng_start_addr_out, eng_byte_len_out, grant_id_out}, 0);
    rst = 1'b0;
    mdl_ptr = 0;
    do_txn(3'b011, 3);
    do_txn(3'b010, 3);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [NREQ-1:0] vm;
      int lat;
      for (int i = 0; i < NREQ; i++) rand_desc(i);
      vm  = NREQ'($urandom_range(1, 7));
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO + 1, TMO + 12)
                                        : $urandom_range(1, TMO);
      do_txn(vm, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
